tdm_demux14: RTL and testbench
==============================

Name: tdm_demux14

Overview:
- Receive end of the team's 4:1 channel multiplexer: accepts a time-division-multiplexed stream of 4 channel words, one word per enabled beat, with a frame marker on slot 0.
- Locks to the frame marker and reassembles each complete frame.
- Presents the 4 channel words in parallel on y0..y3, with a one-cycle frame-valid strobe.
- Sits between the serial link and the per-channel consumers.

Parameters:
- WIDTH, 8, bit width of each channel word (din and y0..y3); legal range is 1 to 32.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  beat qualifier; din/sync are sampled only on clk edges where en=1.
- sync  input  1  frame marker; high on the slot-0 beat of each frame.
- din  input  WIDTH  multiplexed channel word for the current slot.
- y0  output  WIDTH  channel 0 word of last complete frame.
- y1  output  WIDTH  channel 1 word of last complete frame.
- y2  output  WIDTH  channel 2 word of last complete frame.
- y3  output  WIDTH  channel 3 word of last complete frame.
- frame_valid  output  1  one-cycle pulse when y0..y3 update.
- locked  output  1  high while state is LOCKED.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (asynchronous, active-high):
  - On rst=1, immediately: state=SEARCH, slot=0, shadow[0..2]=0, y0..y3=0, frame_valid=0, locked=0, sync_err=0.
  - A reset in the middle of a frame discards the partial frame. y0..y3 return to 0.
- Internal state:
  - 2-bit slot counter.
  - shadow registers shadow[0..2], each WIDTH bits.
  - FSM with states {SEARCH, LOCKED}.
- en=0: all state holds. frame_valid and sync_err are 0 in any cycle that follows an en=0 edge.
- SEARCH state:
  - Beat with sync=0: discarded, no pulse.
  - Beat with sync=1: shadow[0]<=din, slot<=1, state<=LOCKED.
- LOCKED state, beat with slot=1 or 2, sync=0: shadow[slot]<=din, slot<=slot+1.
- LOCKED state, beat with slot=3, sync=0 (frame complete):
  - y0<=shadow[0], y1<=shadow[1], y2<=shadow[2], y3<=din.
  - frame_valid<=1 for exactly one cycle; slot wraps to 0.
  - Latency: outputs and frame_valid are visible in the cycle after the clk edge that samples the slot-3 beat.
- LOCKED state, beat with slot=0, sync=1: normal start of frame. shadow[0]<=din, slot<=1.
- LOCKED state, beat with slot!=0, sync=1 (early marker):
  - sync_err pulses one cycle and the partial frame is discarded.
  - The beat is taken as slot 0: shadow[0]<=din, slot<=1. State stays LOCKED.
- LOCKED state, beat with slot=0, sync=0 (missing marker):
  - sync_err pulses one cycle and the beat is discarded.
  - state<=SEARCH, slot<=0.
- Output stability:
  - y0..y3 change only on a frame-complete edge; otherwise they hold the last complete frame.
  - Partial frames never reach y0..y3.
- Exclusivity: frame_valid and sync_err are never high in the same cycle. A single beat produces at most one of them.
- locked is a registered decode of state.
- Back-to-back frames, with en=1 every cycle: frame_valid pulses every 4th cycle with no dead beats.

Test Plan:
1. Reset, then stream beats (sync on first) 0x11,0x22,0x33,0x44 with en=1 continuously -> one cycle after the 4th beat: y0..y3=0x11,0x22,0x33,0x44, frame_valid=1 for 1 cycle, locked=1 from the 2nd cycle on.
2. Two back-to-back frames 0xA0..A3 then 0xB0..B3, en gapped (en=1 every other cycle) -> frame_valid pulses exactly twice. y holds 0xA0..A3 until the 0xB3 beat is sampled, then becomes 0xB0..B3. No output change on en=0 cycles.
3. While locked, assert sync on slot 2 with din=0x55, then 0x66,0x77,0x88 -> sync_err 1-cycle pulse. No frame_valid for the broken frame. Next frame_valid gives y=0x55,0x66,0x77,0x88.
4. While locked, after a full frame send a slot-0 beat with sync=0 -> sync_err pulse, locked=0, y unchanged. Subsequent non-sync beats are ignored until a sync beat relocks.
5. Assert rst asynchronously (between clk edges) after 2 beats of a frame -> all outputs 0 immediately, locked=0. The following full frame 0x01..0x04 is reassembled correctly.
6. WIDTH=1: frame 1,0,1,1 -> y0..y3=1,0,1,1 with a single frame_valid pulse.

Source files
------------

// File: rtl/tdm_demux14.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux14
//  Purpose  : Receive end of the 4:1 TDM channel multiplexer. Locks to the
//             slot-0 frame marker, collects slots 0..2 in shadow registers and
//             presents a complete frame on y0..y3 when the slot-3 beat lands,
//             with a one-cycle frame_valid strobe. Framing violations raise a
//             one-cycle sync_err pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tdm_demux14 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [0:0] c_SEARCH = 1'b0;
  localparam logic [0:0] c_LOCKED = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic [1:0]       slot_q,   slot_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d;
  logic [WIDTH-1:0] shadow1_q, shadow1_d;
  logic [WIDTH-1:0] shadow2_q, shadow2_d;
  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic [WIDTH-1:0] y3_q, y3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q,    sync_err_d;
  logic             locked_q,      locked_d;

  // Next-state logic: everything holds unless a qualified beat arrives;
  // strobes default low so they last exactly one cycle.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow0_d     = shadow0_q;
    shadow1_d     = shadow1_q;
    shadow2_d     = shadow2_q;
    y0_d          = y0_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    y3_d          = y3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (en) begin
      if (state_q == c_SEARCH) begin
        // Only a marker beat can start a frame while searching.
        if (sync) begin
          shadow0_d = din;
          slot_d    = 2'd1;
          state_d   = c_LOCKED;
        end
      end else begin
        if (sync) begin
          // Marker anywhere but slot 0 means the partial frame is lost;
          // either way the beat becomes the new slot 0.
          sync_err_d = (slot_q != 2'd0);
          shadow0_d  = din;
          slot_d     = 2'd1;
        end else begin
          case (slot_q)
            2'd0: begin
              // Expected marker did not show up: drop lock.
              sync_err_d = 1'b1;
              state_d    = c_SEARCH;
              slot_d     = 2'd0;
            end
            2'd1: begin
              shadow1_d = din;
              slot_d    = 2'd2;
            end
            2'd2: begin
              shadow2_d = din;
              slot_d    = 2'd3;
            end
            default: begin
              // Slot 3 completes the frame; slot 3 goes straight to y3.
              y0_d          = shadow0_q;
              y1_d          = shadow1_q;
              y2_d          = shadow2_q;
              y3_d          = din;
              frame_valid_d = 1'b1;
              slot_d        = 2'd0;
            end
          endcase
        end
      end
    end

    locked_d = (state_d == c_LOCKED);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= c_SEARCH;
      slot_q        <= 2'd0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      shadow2_q     <= shadow2_d;
      y0_q          <= y0_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      y3_q          <= y3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux14.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux14
//  Purpose  : Self-checking bench for tdm_demux14 (WIDTH=8 and WIDTH=1).
//             A queue-based frame model tracks the expected outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tdm_demux14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] din = 8'h00;
  logic [0:0] din1 = 1'b0;
  logic [7:0] y0, y1, y2, y3;
  logic       frame_valid, locked, sync_err;
  logic [0:0] n0, n1, n2, n3;
  logic       n_fv, n_locked, n_err;

  int vectors = 0;
  int errors  = 0;

  // Reference model: collected words of the current frame, last frame, strobes.
  logic [7:0] m_q[$];
  logic [7:0] m_y[4];
  logic       m_locked, m_fv, m_err;

  always #5 clk = ~clk;

  tdm_demux14 #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  tdm_demux14 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din1),
    .y0(n0), .y1(n1), .y2(n2), .y3(n3),
    .frame_valid(n_fv), .locked(n_locked), .sync_err(n_err)
  );

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < 4; i++) m_y[i] = 8'h00;
    m_locked = 1'b0;
    m_fv = 1'b0;
    m_err = 1'b0;
  endtask

  // Drive one cycle, let it be sampled, then advance the model by that beat.
  task automatic step(input logic e, input logic s, input logic [7:0] d);
    en = e; sync = s; din = d; din1 = d[0];
    @(posedge clk);
    #1;
    m_fv = 1'b0;
    m_err = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin m_q = {d}; m_locked = 1'b1; end
      end else if (s) begin
        if (m_q.size() != 0) m_err = 1'b1;
        m_q = {d};
      end else if (m_q.size() == 0) begin
        m_err = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
          m_fv = 1'b1;
          m_q = {};
        end
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({y0, y1, y2, y3, frame_valid, locked, sync_err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got y=%h %h %h %h fv=%b lk=%b err=%b, want all 0",
               y0, y1, y2, y3, frame_valid, locked, sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; sync = 1'b0; din = 8'h00;
    do_reset();
  endtask

  task automatic test_basic();
    logic [7:0] w[4];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, w[i]);
      vectors++;
      if (locked !== 1'b1 || frame_valid !== (i == 3) || sync_err !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d: got lk=%b fv=%b err=%b, want lk=1 fv=%b err=0",
                 i, locked, frame_valid, sync_err, i == 3);
      end
    end
    vectors++;
    if ({y0, y1, y2, y3} !== 32'h11223344) begin
      errors++;
      $display("FAIL basic_frame: got %h%h%h%h want 11223344", y0, y1, y2, y3);
    end
    step(1'b0, 1'b0, 8'h00);
    vectors++;
    if (frame_valid !== 1'b0 || {y0, y1, y2, y3} !== 32'h11223344) begin
      errors++;
      $display("FAIL basic_pulse_len: got fv=%b y=%h%h%h%h want fv=0 y=11223344",
               frame_valid, y0, y1, y2, y3);
    end
  endtask

  task automatic test_back_to_back_gapped();
    int pulses = 0;
    logic [31:0] exp_y;
    exp_y = 32'h11223344;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, i == 0, (f == 0 ? 8'hA0 : 8'hB0) + 8'(i));
        if (frame_valid) pulses++;
        if (f == 0 && i == 3) exp_y = 32'hA0A1A2A3;
        if (f == 1 && i == 3) exp_y = 32'hB0B1B2B3;
        vectors++;
        if ({y0, y1, y2, y3} !== exp_y) begin
          errors++;
          $display("FAIL gapped_y f%0d b%0d: got %h%h%h%h want %h", f, i, y0, y1, y2, y3, exp_y);
        end
        step(1'b0, 1'b1, 8'hEE);
        vectors++;
        if ({y0, y1, y2, y3} !== exp_y || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
          errors++;
          $display("FAIL gapped_idle f%0d b%0d: got y=%h%h%h%h fv=%b err=%b want y=%h fv=0 err=0",
                   f, i, y0, y1, y2, y3, frame_valid, sync_err, exp_y);
        end
      end
    end
    vectors++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL gapped_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_early_sync();
    step(1'b1, 1'b1, 8'hC0);
    step(1'b1, 1'b0, 8'hC1);
    step(1'b1, 1'b1, 8'h55);
    vectors++;
    if (sync_err !== 1'b1 || frame_valid !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL early_err: got err=%b fv=%b lk=%b want err=1 fv=0 lk=1",
               sync_err, frame_valid, locked);
    end
    step(1'b1, 1'b0, 8'h66);
    vectors++;
    if (sync_err !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_pulse_len: got err=%b fv=%b want 0 0", sync_err, frame_valid);
    end
    step(1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b0, 8'h88);
    vectors++;
    if (frame_valid !== 1'b1 || {y0, y1, y2, y3} !== 32'h55667788) begin
      errors++;
      $display("FAIL early_frame: got fv=%b y=%h%h%h%h want fv=1 y=55667788",
               frame_valid, y0, y1, y2, y3);
    end
  endtask

  task automatic test_missing_sync();
    step(1'b1, 1'b0, 8'h99);
    vectors++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || {y0, y1, y2, y3} !== 32'h55667788) begin
      errors++;
      $display("FAIL missing_err: got err=%b lk=%b y=%h%h%h%h want err=1 lk=0 y=55667788",
               sync_err, locked, y0, y1, y2, y3);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'(8'h10 + i));
      vectors++;
      if (sync_err !== 1'b0 || frame_valid !== 1'b0 || locked !== 1'b0 ||
          {y0, y1, y2, y3} !== 32'h55667788) begin
        errors++;
        $display("FAIL missing_ignore%0d: got err=%b fv=%b lk=%b y=%h%h%h%h", i,
                 sync_err, frame_valid, locked, y0, y1, y2, y3);
      end
    end
    step(1'b1, 1'b1, 8'h5A);
    vectors++;
    if (locked !== 1'b1 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL missing_relock: got lk=%b err=%b want lk=1 err=0", locked, sync_err);
    end
  endtask

  task automatic test_async_reset();
    // Currently locked at slot 1; add one more beat to be two beats in.
    step(1'b1, 1'b0, 8'h5B);
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, 8'(i + 1));
      vectors++;
      if (frame_valid !== (i == 3) || locked !== 1'b1) begin
        errors++;
        $display("FAIL rst_relock_b%0d: got fv=%b lk=%b want fv=%b lk=1",
                 i, frame_valid, locked, i == 3);
      end
    end
    vectors++;
    if ({y0, y1, y2, y3} !== 32'h01020304) begin
      errors++;
      $display("FAIL rst_frame: got %h%h%h%h want 01020304", y0, y1, y2, y3);
    end
  endtask

  task automatic test_width1();
    logic [3:0] bits;
    bits = 4'b1011;
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, {7'd0, bits[3-i]});
      vectors++;
      if (n_fv !== (i == 3)) begin
        errors++;
        $display("FAIL w1_fv_b%0d: got %b want %b", i, n_fv, i == 3);
      end
    end
    vectors++;
    if ({n0, n1, n2, n3} !== 4'b1011) begin
      errors++;
      $display("FAIL w1_frame: got %b%b%b%b want 1011", n0, n1, n2, n3);
    end
    step(1'b1, 1'b1, 8'h00);
    vectors++;
    if (n_fv !== 1'b0) begin
      errors++;
      $display("FAIL w1_pulse_len: got %b want 0", n_fv);
    end
  endtask

  task automatic test_random();
    logic e, s;
    logic [7:0] d;
    for (int n = 0; n < 400; n++) begin
      e = ($urandom_range(0, 3) != 0);
      // Mostly well-formed framing, with occasional stray or missing markers.
      if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 1) == 1;
      else s = (m_q.size() == 0);
      d = 8'($urandom);
      step(e, s, d);
      vectors++;
      if ({y0, y1, y2, y3, frame_valid, locked, sync_err} !==
          {m_y[0], m_y[1], m_y[2], m_y[3], m_fv, m_locked, m_err} ||
          (frame_valid && sync_err)) begin
        errors++;
        $display("FAIL rand%0d: got y=%h%h%h%h fv=%b lk=%b err=%b want y=%h%h%h%h fv=%b lk=%b err=%b",
                 n, y0, y1, y2, y3, frame_valid, locked, sync_err,
                 m_y[0], m_y[1], m_y[2], m_y[3], m_fv, m_locked, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back_gapped();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    test_width1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
